// File: rtl/sram_responder.sv
// sram_responder: single-outstanding memory responder for the CPU request side.
// Accepts one fetch or one data read/write at a time, waits LATENCY cycles,
// then returns a one-cycle valid pulse with the (post-merge) RAM word.
// Optional build macro: SRAM_RESPONDER_PERF_EN adds response counters.
module sram_responder #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] inst_addr,
    input  logic        inst_ren,
    output logic        inst_valid,
    output logic [31:0] inst_rd,
    input  logic [31:0] data_addr,
    input  logic        data_ren,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_wdata,
    output logic        data_valid,
    output logic [31:0] data_rd
`ifdef SRAM_RESPONDER_PERF_EN
    ,
    output logic [31:0] perf_inst_cnt,
    output logic [31:0] perf_data_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {KIND_INST, KIND_DATA} kind_t;

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                state, state_nx;
    kind_t                 kind, kind_nx;
    logic [3:0]            cnt, cnt_nx;
    logic                  accept;
    logic                  fire;

    logic [DEPTH_LOG2-1:0] idx_p0;
    logic [3:0]            wen_p0;
    logic [31:0]           wdata_p0;
    logic [31:0]           mem [DEPTH];
    logic [31:0]           merged;

    // Only the word-index bits of each address select a RAM word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr, data_addr};

    // Replace the enabled byte lanes of a RAM word with write data.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wen);
        logic [31:0] w;
        w = old_word;
        for (int b = 0; b < 4; b++) begin
            if (wen[b]) w[8*b +: 8] = wdata[8*b +: 8];
        end
        return w;
    endfunction

    // Word returned on the response edge; for writes this is the merged word.
    assign merged = merge_bytes(mem[idx_p0], wdata_p0, wen_p0);

    // Next-state logic: accept in IDLE (data over fetch), count down in BUSY.
    always_comb begin
        state_nx = state;
        kind_nx  = kind;
        cnt_nx   = cnt;
        accept   = 1'b0;
        fire     = 1'b0;
        case (state)
            IDLE: begin
                if (data_wen != 4'b0000 || data_ren) begin
                    accept   = 1'b1;
                    kind_nx  = KIND_DATA;
                    state_nx = BUSY;
                    cnt_nx   = CNT_INIT;
                end else if (inst_ren) begin
                    accept   = 1'b1;
                    kind_nx  = KIND_INST;
                    state_nx = BUSY;
                    cnt_nx   = CNT_INIT;
                end
            end
            BUSY: begin
                // Only fetches can be aborted; data accesses always complete.
                if (flush && kind == KIND_INST) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nx = RESP;
                    fire     = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Control state, response pulses and held read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            kind       <= KIND_INST;
            cnt        <= 4'd0;
            inst_valid <= 1'b0;
            data_valid <= 1'b0;
            inst_rd    <= 32'd0;
            data_rd    <= 32'd0;
        end else begin
            state      <= state_nx;
            kind       <= kind_nx;
            cnt        <= cnt_nx;
            inst_valid <= fire && (kind == KIND_INST);
            data_valid <= fire && (kind == KIND_DATA);
            if (fire && kind == KIND_INST) inst_rd <= merged;
            if (fire && kind == KIND_DATA) data_rd <= merged;
        end
    end

    // Request capture stage: latch word index, byte enables and write data.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (kind_nx == KIND_DATA) begin
                idx_p0 <= data_addr[DEPTH_LOG2+1:2];
                wen_p0 <= data_wen;
            end else begin
                idx_p0 <= inst_addr[DEPTH_LOG2+1:2];
                wen_p0 <= 4'b0000;
            end
            wdata_p0 <= data_wdata;
        end
    end

    // RAM write on the response edge; a reset in that cycle cancels it.
    always_ff @(posedge clk) begin
        if (!rst && fire && wen_p0 != 4'b0000) begin
            mem[idx_p0] <= merged;
        end
    end

`ifdef SRAM_RESPONDER_PERF_EN
    // Response counters, bumped on the edge each valid pulse rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_inst_cnt <= 32'd0;
            perf_data_cnt <= 32'd0;
        end else if (fire) begin
            if (kind == KIND_INST) perf_inst_cnt <= perf_inst_cnt + 32'd1;
            else                   perf_data_cnt <= perf_data_cnt + 32'd1;
        end
    end
`endif

endmodule
